// File: rtl/qda_dac_pkg.sv
// -----------------------------------------------------------------------------
// qda_dac_pkg
// Shared definitions for the QDA front-end DAC serial loader.
//   - qda_state_e        : frame state machine encoding
//   - DATA_WIDTH_DEFAULT : default frame width in bits
//   - CNT_WIDTH          : width of the period counters and period inputs
//   - idx_width()        : bit-index width for a given frame width (min 1)
//   - period_minus1()    : counter reload value for a period, treating 0 as 1
// -----------------------------------------------------------------------------
package qda_dac_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int CNT_WIDTH          = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCLK_LOW  = 2'd1,
        SCLK_HIGH = 2'd2,
        LATCH     = 2'd3
    } qda_state_e;

    function automatic int idx_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    // A period of P cycles is counted as a reload of P-1 followed by a
    // terminal count at zero; a programmed 0 is treated the same as 1.
    function automatic logic [CNT_WIDTH-1:0] period_minus1(input logic [CNT_WIDTH-1:0] p);
        return (p == '0) ? '0 : p - 1'b1;
    endfunction

endpackage

// File: rtl/qda_dac_control_if.sv
// -----------------------------------------------------------------------------
// qda_dac_control_if
// Register-side controls and DAC-side pins of the serial loader.
//   LOAD_PERIOD  [15:0]  SCLK half-period in clk cycles (0 behaves as 1)
//   LATCH_PERIOD [15:0]  PCLK high time in clk cycles (0 behaves as 1)
//   UPDATE               start request, level-sampled while idle
//   REG_DATA     [DW-1:0] word to transmit
//   SIN                  serial data, MSB first
//   SCLK                 serial clock, DAC samples SIN on its rising edge
//   PCLK                 parallel-load strobe, active-high
// Modports: master = register/control side, slave = the loader.
// -----------------------------------------------------------------------------
interface qda_dac_control_if
    import qda_dac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

    logic [CNT_WIDTH-1:0]  LOAD_PERIOD;
    logic [CNT_WIDTH-1:0]  LATCH_PERIOD;
    logic                  UPDATE;
    logic [DATA_WIDTH-1:0] REG_DATA;
    logic                  SIN;
    logic                  SCLK;
    logic                  PCLK;

    modport master (
        output LOAD_PERIOD, LATCH_PERIOD, UPDATE, REG_DATA,
        input  SIN, SCLK, PCLK
    );

    modport slave (
        input  LOAD_PERIOD, LATCH_PERIOD, UPDATE, REG_DATA,
        output SIN, SCLK, PCLK
    );

endinterface

// File: rtl/qda_period_counter.sv
// -----------------------------------------------------------------------------
// qda_period_counter
// Loadable 16-bit down-counter that stops at zero. Used to time both the SCLK
// half-periods and the PCLK strobe width.
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   i_load         in   load i_load_value this cycle (priority over counting)
//   i_load_value   in   reload value (period minus one)
//   o_tc           out  terminal count: counter is at zero
// -----------------------------------------------------------------------------
module qda_period_counter
    import qda_dac_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_value,
    output logic                 o_tc
);

    logic [CNT_WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments only, and the
    // reset is tested inside the clocked block so it is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/qda_dac_control.sv
// -----------------------------------------------------------------------------
// qda_dac_control
// Serial loader for the QDA front-end DAC. An UPDATE seen while idle captures
// REG_DATA and both periods, shifts the word out MSB-first on SIN with a
// generated SCLK, then raises PCLK for the latch time.
//   clk   in   system clock, all logic on the rising edge
//   rst   in   synchronous active-high reset; aborts any frame in flight
//   bus   slave modport of qda_dac_control_if (controls in, DAC pins out)
// Frame length is 2*DATA_WIDTH*N + M cycles, with N/M the effective periods.
// -----------------------------------------------------------------------------
module qda_dac_control
    import qda_dac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    qda_dac_control_if.slave  bus
);

    localparam int               IDX_W    = idx_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    qda_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [CNT_WIDTH-1:0]  r_n_m1;      // shadowed SCLK half-period minus one
    logic [CNT_WIDTH-1:0]  r_m_m1;      // shadowed PCLK width minus one
    logic                  r_sin;
    logic                  r_sclk;
    logic                  r_pclk;

    logic                  w_tc;
    logic                  w_cnt_load;
    logic [CNT_WIDTH-1:0]  w_cnt_value;
    logic                  w_last_bit;
    logic [DATA_WIDTH-1:0] w_shift_next;

    // Counter reload: at frame start from the live input (the shadow is being
    // written on the same edge), at each SCLK phase end from the shadows.
    // NOTE: every signal driven here gets a default first so no latch forms.
    always_comb begin
        w_last_bit   = (r_bit_idx == LAST_IDX);
        w_shift_next = r_shift << 1;
        w_cnt_load   = 1'b0;
        w_cnt_value  = r_n_m1;
        case (r_state)
            IDLE: begin
                w_cnt_load  = bus.UPDATE;
                w_cnt_value = period_minus1(bus.LOAD_PERIOD);
            end
            SCLK_LOW: begin
                w_cnt_load = w_tc;
            end
            SCLK_HIGH: begin
                w_cnt_load = w_tc;
                if (w_last_bit) begin
                    w_cnt_value = r_m_m1;
                end
            end
            default: begin
                w_cnt_load = 1'b0;
            end
        endcase
    end

    qda_period_counter u_period_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_value),
        .o_tc         (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_n_m1    <= '0;
            r_m_m1    <= '0;
            r_sin     <= 1'b0;
            r_sclk    <= 1'b0;
            r_pclk    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sclk <= 1'b0;
                    r_pclk <= 1'b0;
                    r_sin  <= 1'b0;
                    if (bus.UPDATE) begin
                        r_shift   <= bus.REG_DATA;
                        r_sin     <= bus.REG_DATA[DATA_WIDTH-1];
                        r_bit_idx <= '0;
                        r_n_m1    <= period_minus1(bus.LOAD_PERIOD);
                        r_m_m1    <= period_minus1(bus.LATCH_PERIOD);
                        r_state   <= SCLK_LOW;
                    end
                end
                SCLK_LOW: begin
                    if (w_tc) begin
                        r_sclk  <= 1'b1;
                        r_state <= SCLK_HIGH;
                    end
                end
                SCLK_HIGH: begin
                    if (w_tc) begin
                        r_sclk <= 1'b0;
                        if (w_last_bit) begin
                            // SIN keeps the LSB through the strobe.
                            r_pclk  <= 1'b1;
                            r_state <= LATCH;
                        end else begin
                            // SIN moves only with the SCLK falling edge.
                            r_shift   <= w_shift_next;
                            r_sin     <= w_shift_next[DATA_WIDTH-1];
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_state   <= SCLK_LOW;
                        end
                    end
                end
                LATCH: begin
                    if (w_tc) begin
                        r_pclk  <= 1'b0;
                        r_sin   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.SIN  = r_sin;
    assign bus.SCLK = r_sclk;
    assign bus.PCLK = r_pclk;

endmodule

// File: tb/tb_qda_dac_control.sv
// -----------------------------------------------------------------------------
// tb_qda_dac_control
// Self-checking bench for qda_dac_control. Expected pin values are computed
// per cycle from the frame timing rules (bit k occupies 2N cycles, SCLK high
// in the second half; then M cycles of PCLK; then idle).
// -----------------------------------------------------------------------------
module tb_qda_dac_control;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    qda_dac_control_if #(.DATA_WIDTH(DW)) bus ();

    qda_dac_control #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic int frame_len(input int n, input int m);
        return 2 * DW * n + m;
    endfunction

    // Expected {SIN, SCLK, PCLK} t cycles after the start edge.
    function automatic logic [2:0] exp_out(input int t, input logic [DW-1:0] d,
                                           input int n, input int m);
        int k;
        if (t < 2 * DW * n) begin
            k = t / (2 * n);
            return {d[DW-1-k], ((t % (2 * n)) >= n), 1'b0};
        end else if (t < 2 * DW * n + m) begin
            return {d[0], 1'b0, 1'b1};
        end
        return 3'b000;
    endfunction

    function automatic logic [2:0] obs();
        return {bus.SIN, bus.SCLK, bus.PCLK};
    endfunction

    // Drives a start request; returns #1 after the sampling edge (t = 0).
    task automatic start_frame(input logic [DW-1:0] d, input int lp, input int mp,
                               input bit hold);
        @(negedge clk);
        bus.REG_DATA     = d;
        bus.LOAD_PERIOD  = 16'(lp);
        bus.LATCH_PERIOD = 16'(mp);
        bus.UPDATE       = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.UPDATE = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.UPDATE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (obs() !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=000", obs());
        end
        n_checks++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (obs() !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=000", i, obs());
            end
            n_checks++;
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] word = '0;
        int rises = 0, first_rise = -1, bad_gap = 0, prev_rise = -1;
        int pclk_cyc = 0, first_pclk = -1;
        logic prev_sclk = 1'b0;
        logic [2:0] o;
        start_frame(16'hAAAA, 10, 10, 1'b0);
        for (int t = 0; t <= 330; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            o = obs();
            if (o !== exp_out(t, 16'hAAAA, 10, 10)) begin
                n_fail++;
                $display("FAIL basic t=%0d got=%b exp=%b", t, o, exp_out(t, 16'hAAAA, 10, 10));
            end
            n_checks++;
            if (o[1] && !prev_sclk) begin
                if (first_rise < 0) first_rise = t;
                if (prev_rise >= 0 && t - prev_rise != 20) bad_gap++;
                prev_rise = t;
                rises++;
                word = {word[DW-2:0], o[2]};
            end
            prev_sclk = o[1];
            if (o[0]) begin
                if (first_pclk < 0) first_pclk = t;
                pclk_cyc++;
            end
        end
        if (rises !== 16)      begin n_fail++; $display("FAIL basic_rises got=%0d exp=16", rises); end
        n_checks++;
        if (first_rise !== 10) begin n_fail++; $display("FAIL basic_first_rise got=%0d exp=10", first_rise); end
        n_checks++;
        if (bad_gap !== 0)     begin n_fail++; $display("FAIL basic_rise_spacing bad=%0d exp=0", bad_gap); end
        n_checks++;
        if (word !== 16'hAAAA) begin n_fail++; $display("FAIL basic_word got=%h exp=aaaa", word); end
        n_checks++;
        if (first_pclk !== 320 || pclk_cyc !== 10) begin
            n_fail++;
            $display("FAIL basic_pclk start=%0d width=%0d exp start=320 width=10", first_pclk, pclk_cyc);
        end
        n_checks++;
    endtask

    task automatic test_zero_periods();
        logic [DW-1:0] word = '0;
        int pclk_cyc = 0;
        logic prev_sclk = 1'b0;
        logic [2:0] o;
        start_frame(16'h8001, 0, 0, 1'b0);
        for (int t = 0; t <= 33; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            o = obs();
            if (o !== exp_out(t, 16'h8001, 1, 1)) begin
                n_fail++;
                $display("FAIL zero t=%0d got=%b exp=%b", t, o, exp_out(t, 16'h8001, 1, 1));
            end
            n_checks++;
            if (o[1] && !prev_sclk) word = {word[DW-2:0], o[2]};
            prev_sclk = o[1];
            if (o[0]) pclk_cyc++;
        end
        if (word !== 16'h8001 || pclk_cyc !== 1) begin
            n_fail++;
            $display("FAIL zero_summary word=%h pclk=%0d exp word=8001 pclk=1", word, pclk_cyc);
        end
        n_checks++;
    endtask

    task automatic test_busy_shadow();
        int len = frame_len(7, 5);
        int pulses = 0, both_high = 0;
        logic prev_pclk = 1'b0;
        logic [2:0] o;
        start_frame(16'h1234, 7, 5, 1'b0);
        for (int t = 0; t <= len + 20; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            o = obs();
            if (o !== exp_out(t, 16'h1234, 7, 5)) begin
                n_fail++;
                $display("FAIL busy t=%0d got=%b exp=%b", t, o, exp_out(t, 16'h1234, 7, 5));
            end
            n_checks++;
            if (o[0] && !prev_pclk) pulses++;
            if (o[0] && o[1]) both_high++;
            prev_pclk = o[0];
            if (t == 40) begin
                bus.UPDATE       = 1'b1;
                bus.REG_DATA     = 16'hFFFF;
                bus.LOAD_PERIOD  = 16'd3;
                bus.LATCH_PERIOD = 16'd9;
            end
            if (t == 41) bus.UPDATE = 1'b0;
        end
        if (pulses !== 1) begin n_fail++; $display("FAIL busy_pclk_pulses got=%0d exp=1", pulses); end
        n_checks++;
        if (both_high !== 0) begin n_fail++; $display("FAIL busy_overlap got=%0d exp=0", both_high); end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        int len = frame_len(2, 4);   // 68
        int per = len + 1;           // one idle cycle between frames
        logic [2:0] e;
        start_frame(16'h00FF, 2, 4, 1'b1);
        for (int t = 0; t <= 3 * per + 5; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            e = (t < 3 * per) ? exp_out(t % per, 16'h00FF, 2, 4) : 3'b000;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL held t=%0d got=%b exp=%b", t, obs(), e);
            end
            n_checks++;
            if (t == 2 * per + 12) bus.UPDATE = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] d = 16'($urandom);
        logic [DW-1:0] d2 = 16'($urandom);
        int pclk_seen = 0;
        start_frame(d, 3, 3, 1'b0);
        // Bit 7 spans t = 42..47 for N = 3.
        for (int t = 0; t <= 44; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            if (obs() !== exp_out(t, d, 3, 3)) begin
                n_fail++;
                $display("FAIL rstmid t=%0d got=%b exp=%b", t, obs(), exp_out(t, d, 3, 3));
            end
            n_checks++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (obs() !== 3'b000) begin n_fail++; $display("FAIL rstmid_next_edge got=%b exp=000", obs()); end
        n_checks++;
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (obs() !== 3'b000) pclk_seen++;
        end
        if (pclk_seen !== 0) begin n_fail++; $display("FAIL rstmid_quiet active=%0d exp=0", pclk_seen); end
        n_checks++;
        start_frame(d2, 1, 2, 1'b0);
        for (int t = 0; t <= frame_len(1, 2) + 1; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            if (obs() !== exp_out(t, d2, 1, 2)) begin
                n_fail++;
                $display("FAIL rstmid_clean t=%0d got=%b exp=%b", t, obs(), exp_out(t, d2, 1, 2));
            end
            n_checks++;
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        int lp, mp, n, m;
        for (int f = 0; f < 8; f++) begin
            d  = 16'($urandom);
            lp = $urandom_range(0, 4);
            mp = $urandom_range(0, 6);
            n  = eff(lp);
            m  = eff(mp);
            start_frame(d, lp, mp, 1'b0);
            for (int t = 0; t <= frame_len(n, m) + 2; t++) begin
                if (t > 0) begin @(posedge clk); #1; end
                if (obs() !== exp_out(t, d, n, m)) begin
                    n_fail++;
                    $display("FAIL random f=%0d t=%0d d=%h lp=%0d mp=%0d got=%b exp=%b",
                             f, t, d, lp, mp, obs(), exp_out(t, d, n, m));
                end
                n_checks++;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        bus.UPDATE       = 1'b0;
        bus.REG_DATA     = '0;
        bus.LOAD_PERIOD  = '0;
        bus.LATCH_PERIOD = '0;
        test_reset();
        test_basic();
        test_zero_periods();
        test_busy_shadow();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
